// File: rtl/sd_reg_bank.sv
// sd_reg_bank: SD card register set (CID, RCA, DSR, CSD, SCR, OCR, STATUS).
// Each register takes full-width parallel writes or an MSB-first serial load
// that commits atomically.
// A word-addressed read port serves the host bus, and RCA is exported directly.
// Optional feature macro: SD_REG_CRC7_EN adds a CRC7 trailer check to every
// serial load. Without it, the load commits on the last payload bit.
module sd_reg_bank #(
  parameter int RD_WIDTH = 32,
  parameter int WAW      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [2:0]          wr_sel,
  input  logic [127:0]        wr_data,
  input  logic                ld_start,
  input  logic [2:0]          ld_sel,
  input  logic                ld_bit_valid,
  input  logic                ld_bit,
  input  logic                ld_abort,
  output logic                ld_busy,
  output logic                ld_done,
  output logic                ld_err,
  input  logic [2:0]          rd_sel,
  input  logic [WAW-1:0]      rd_word,
  output logic [RD_WIDTH-1:0] rd_data,
  output logic [15:0]         rca_out
);

  localparam int NWORDS = 128 / RD_WIDTH;

  localparam logic [2:0] SEL_CID  = 3'd0;
  localparam logic [2:0] SEL_RCA  = 3'd1;
  localparam logic [2:0] SEL_DSR  = 3'd2;
  localparam logic [2:0] SEL_CSD  = 3'd3;
  localparam logic [2:0] SEL_SCR  = 3'd4;
  localparam logic [2:0] SEL_OCR  = 3'd5;
  localparam logic [2:0] SEL_STAT = 3'd6;

  localparam logic [15:0]  DSR_RST = 16'h0404;
  localparam logic [127:0] CSD_RST = 128'h0000_0048_0000_0000_0000_0000_0000_0000;
  localparam logic [31:0]  OCR_RST = 32'h0060_0000;

`ifdef SD_REG_CRC7_EN
  // The CRC trailer arrives after the payload, so the whole payload must be held.
  localparam int SHIFT_W = 128;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_CRC = 2'd2} ld_state_t;
`else
  // The last payload bit is taken straight from ld_bit on the commit edge,
  // so only 127 bits ever need to be stored.
  localparam int SHIFT_W = 127;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} ld_state_t;
`endif

  // Register widths in bits, indexed by select code; 0 for the reserved code.
  function automatic logic [7:0] reg_width(input logic [2:0] sel);
    case (sel)
      SEL_CID, SEL_CSD:   reg_width = 8'd128;
      SEL_RCA, SEL_DSR:   reg_width = 8'd16;
      SEL_SCR, SEL_STAT:  reg_width = 8'd64;
      SEL_OCR:            reg_width = 8'd32;
      default:            reg_width = 8'd0;
    endcase
  endfunction

  logic [127:0] r_cid;
  logic [15:0]  r_rca;
  logic [15:0]  r_dsr;
  logic [127:0] r_csd;
  logic [63:0]  r_scr;
  logic [31:0]  r_ocr;
  logic [63:0]  r_stat;

  ld_state_t          r_state;
  ld_state_t          w_state_d;
  logic [SHIFT_W-1:0] r_shift;
  logic [SHIFT_W-1:0] w_shift_d;
  logic [SHIFT_W-1:0] w_shift_adv;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt_d;
  logic [2:0]         r_ld_sel;
  logic [2:0]         w_ld_sel_d;
  logic               r_done;
  logic               w_done_d;
  logic               r_err;
  logic               w_err_d;
  logic               w_commit;
  logic               w_collide;
  logic [127:0]       w_commit_data;
  logic [6:0]         w_wr_hit;
  logic [6:0]         w_cm_hit;
  logic [127:0]       w_rd_reg;
`ifdef SD_REG_CRC7_EN
  logic [6:0]         r_crc;
  logic [6:0]         w_crc_d;
  logic [6:0]         w_crc_adv;
  logic [5:0]         r_crc_rx;
  logic [5:0]         w_crc_rx_d;
`endif

  assign w_shift_adv = {r_shift[SHIFT_W-2:0], ld_bit};
  assign w_collide   = wr_en && (wr_sel == r_ld_sel);

`ifdef SD_REG_CRC7_EN
  assign w_commit_data = r_shift;
  assign w_crc_adv     = {r_crc[5:0], 1'b0} ^
                         {3'b000, r_crc[6] ^ ld_bit, 2'b00, r_crc[6] ^ ld_bit};
`else
  assign w_commit_data = {r_shift, ld_bit};
`endif

  // Loader next-state logic: start, shift, optional CRC check, abort and commit.
  always_comb begin
    w_state_d  = r_state;
    w_shift_d  = r_shift;
    w_cnt_d    = r_cnt;
    w_ld_sel_d = r_ld_sel;
    w_commit   = 1'b0;
    w_done_d   = 1'b0;
    w_err_d    = 1'b0;
`ifdef SD_REG_CRC7_EN
    w_crc_d    = r_crc;
    w_crc_rx_d = r_crc_rx;
`endif
    case (r_state)
      ST_IDLE: begin
        if (ld_start) begin
          if (ld_sel != 3'd7) begin
            w_ld_sel_d = ld_sel;
            w_shift_d  = '0;
            w_cnt_d    = reg_width(ld_sel);
            w_state_d  = ST_SHIFT;
`ifdef SD_REG_CRC7_EN
            w_crc_d    = '0;
            w_crc_rx_d = '0;
`endif
          end else begin
            w_done_d = 1'b1;
            w_err_d  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (ld_abort) begin
          w_state_d = ST_IDLE;
          w_done_d  = 1'b1;
          w_err_d   = 1'b1;
        end else if (ld_bit_valid) begin
          w_shift_d = w_shift_adv;
          w_cnt_d   = r_cnt - 8'd1;
`ifdef SD_REG_CRC7_EN
          w_crc_d   = w_crc_adv;
          if (r_cnt == 8'd1) begin
            w_state_d = ST_CRC;
            w_cnt_d   = 8'd7;
          end
`else
          if (r_cnt == 8'd1) begin
            w_state_d = ST_IDLE;
            w_commit  = 1'b1;
            w_done_d  = 1'b1;
            w_err_d   = w_collide;
          end
`endif
        end
      end
`ifdef SD_REG_CRC7_EN
      ST_CRC: begin
        if (ld_abort) begin
          w_state_d = ST_IDLE;
          w_done_d  = 1'b1;
          w_err_d   = 1'b1;
        end else if (ld_bit_valid) begin
          w_crc_rx_d = {r_crc_rx[4:0], ld_bit};
          w_cnt_d    = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_state_d = ST_IDLE;
            w_done_d  = 1'b1;
            if ({r_crc_rx, ld_bit} == r_crc) begin
              w_commit = 1'b1;
              w_err_d  = w_collide;
            end else begin
              w_err_d  = 1'b1;
            end
          end
        end
      end
`endif
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // Loader state register; reset abandons any load without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_ld_sel <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef SD_REG_CRC7_EN
      r_crc    <= '0;
      r_crc_rx <= '0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_cnt    <= w_cnt_d;
      r_ld_sel <= w_ld_sel_d;
      r_done   <= w_done_d;
      r_err    <= w_err_d;
`ifdef SD_REG_CRC7_EN
      r_crc    <= w_crc_d;
      r_crc_rx <= w_crc_rx_d;
`endif
    end
  end

  // Per-register write strobes; a parallel write suppresses a same-target commit.
  always_comb begin
    w_wr_hit = '0;
    w_cm_hit = '0;
    for (int k = 0; k < 7; k++) begin
      w_wr_hit[k] = wr_en && (wr_sel == 3'(k));
      w_cm_hit[k] = w_commit && (r_ld_sel == 3'(k)) && !w_wr_hit[k];
    end
  end

  // Card register storage, updated by parallel writes or loader commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cid  <= '0;
      r_rca  <= '0;
      r_dsr  <= DSR_RST;
      r_csd  <= CSD_RST;
      r_scr  <= '0;
      r_ocr  <= OCR_RST;
      r_stat <= '0;
    end else begin
      if (w_wr_hit[0])      r_cid  <= wr_data;
      else if (w_cm_hit[0]) r_cid  <= w_commit_data;
      if (w_wr_hit[1])      r_rca  <= wr_data[15:0];
      else if (w_cm_hit[1]) r_rca  <= w_commit_data[15:0];
      if (w_wr_hit[2])      r_dsr  <= wr_data[15:0];
      else if (w_cm_hit[2]) r_dsr  <= w_commit_data[15:0];
      if (w_wr_hit[3])      r_csd  <= wr_data;
      else if (w_cm_hit[3]) r_csd  <= w_commit_data;
      if (w_wr_hit[4])      r_scr  <= wr_data[63:0];
      else if (w_cm_hit[4]) r_scr  <= w_commit_data[63:0];
      if (w_wr_hit[5])      r_ocr  <= wr_data[31:0];
      else if (w_cm_hit[5]) r_ocr  <= w_commit_data[31:0];
      if (w_wr_hit[6])      r_stat <= wr_data[63:0];
      else if (w_cm_hit[6]) r_stat <= w_commit_data[63:0];
    end
  end

  // Zero-extend the selected register to 128 bits for word extraction.
  always_comb begin
    w_rd_reg = '0;
    case (rd_sel)
      SEL_CID:  w_rd_reg = r_cid;
      SEL_RCA:  w_rd_reg = {112'd0, r_rca};
      SEL_DSR:  w_rd_reg = {112'd0, r_dsr};
      SEL_CSD:  w_rd_reg = r_csd;
      SEL_SCR:  w_rd_reg = {64'd0, r_scr};
      SEL_OCR:  w_rd_reg = {96'd0, r_ocr};
      SEL_STAT: w_rd_reg = {64'd0, r_stat};
      default:  w_rd_reg = '0;
    endcase
  end

  // Pick the addressed word; word 0 is least significant.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (rd_word == WAW'(i)) rd_data = w_rd_reg[i*RD_WIDTH +: RD_WIDTH];
    end
  end

  assign ld_busy = (r_state != ST_IDLE);
  assign ld_done = r_done;
  assign ld_err  = r_err;
  assign rca_out = r_rca;

endmodule

// File: tb/tb_sd_reg_bank.sv
// tb_sd_reg_bank: self-checking bench for sd_reg_bank (RD_WIDTH = 32).
// Read/write vectors are table driven. Load outcomes go through a queue of
// expected ld_err values, which is consumed on every ld_done pulse.
module tb_sd_reg_bank;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic [2:0]   wr_sel;
  logic [127:0] wr_data;
  logic         ld_start;
  logic [2:0]   ld_sel;
  logic         ld_bit_valid;
  logic         ld_bit;
  logic         ld_abort;
  logic         ld_busy;
  logic         ld_done;
  logic         ld_err;
  logic [2:0]   rd_sel;
  logic [1:0]   rd_word;
  logic [31:0]  rd_data;
  logic [15:0]  rca_out;

`ifdef SD_REG_CRC7_EN
  localparam int CRC_LEN = 7;
`else
  localparam int CRC_LEN = 0;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  logic expQ[$];

  typedef struct {
    logic [2:0]  sel;
    logic [1:0]  word;
    logic [31:0] exp;
  } rdVec_t;

  typedef struct {
    logic [2:0]   wsel;
    logic [127:0] wdata;
    logic [2:0]   rsel;
    logic [1:0]   rword;
    logic [31:0]  exp;
  } wrVec_t;

  rdVec_t resetVecs[10];
  wrVec_t wrVecs[11];

  sd_reg_bank #(.RD_WIDTH(32), .WAW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .ld_start     (ld_start),
    .ld_sel       (ld_sel),
    .ld_bit_valid (ld_bit_valid),
    .ld_bit       (ld_bit),
    .ld_abort     (ld_abort),
    .ld_busy      (ld_busy),
    .ld_done      (ld_done),
    .ld_err       (ld_err),
    .rd_sel       (rd_sel),
    .rd_word      (rd_word),
    .rd_data      (rd_data),
    .rca_out      (rca_out)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [1:0] word);
    rd_sel  = sel;
    rd_word = word;
    #1;
  endtask

  task automatic readCheck(input string name, input logic [2:0] sel, input logic [1:0] word,
                           input logic [31:0] exp);
    applyStimulus(sel, word);
    checkOutput(name, {96'd0, rd_data}, {96'd0, exp});
  endtask

  task automatic runResetTable();
    for (int i = 0; i < 10; i++)
      readCheck($sformatf("reset_rd%0d", i), resetVecs[i].sel, resetVecs[i].word, resetVecs[i].exp);
    checkOutput("reset_rca_out", {112'd0, rca_out}, 128'd0);
  endtask

  // Reference CRC7 (x^7+x^3+1, init 0) over data[n-1:0], MSB first.
  function automatic logic [6:0] crc7(input logic [127:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Wire image of a load: payload, then the CRC trailer when the feature is built in.
  function automatic logic [135:0] mkStream(input logic [127:0] data, input int n, input bit flip);
    logic [135:0] s;
    logic [6:0]   c;
    s = {8'd0, data};
    c = crc7(data, n) ^ (flip ? 7'h01 : 7'h00);
    if (CRC_LEN != 0) s = (s << 7) | {129'd0, c};
    return s;
  endfunction

  task automatic startLoad(input logic [2:0] sel);
    @(negedge clk);
    ld_start = 1'b1;
    ld_sel   = sel;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  // Send s[n-1:0] MSB first; optional idle gaps; optional parallel write on the last bit.
  task automatic sendStream(input logic [135:0] s, input int n, input int gap, input logic doWr,
                            input logic [2:0] wsel, input logic [127:0] wdata);
    for (int i = n - 1; i >= 0; i--) begin
      ld_bit_valid = 1'b1;
      ld_bit       = s[i];
      if (i == 0 && doWr) begin
        wr_en   = 1'b1;
        wr_sel  = wsel;
        wr_data = wdata;
      end
      @(negedge clk);
      wr_en = 1'b0;
      if (gap != 0 && i != 0 && (i % gap) == 0) begin
        ld_bit_valid = 1'b0;
        ld_bit       = 1'b0;
        @(negedge clk);
      end
    end
    ld_bit_valid = 1'b0;
    ld_bit       = 1'b0;
  endtask

  task automatic parWrite(input logic [2:0] wsel, input logic [127:0] wdata);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = wsel;
    wr_data = wdata;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected ld_err.
  always @(posedge clk) begin
    logic e;
    #1;
    if (!reset && ld_done) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_done: got ld_done=1, expected no pulse");
      end else begin
        e = expQ.pop_front();
        checkOutput("ld_err", {127'd0, ld_err}, {127'd0, e});
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [135:0] s;

    resetVecs[0] = '{3'd0, 2'd0, 32'h0};
    resetVecs[1] = '{3'd0, 2'd3, 32'h0};
    resetVecs[2] = '{3'd1, 2'd0, 32'h0};
    resetVecs[3] = '{3'd2, 2'd0, 32'h0000_0404};
    resetVecs[4] = '{3'd3, 2'd3, 32'h0000_0048};
    resetVecs[5] = '{3'd3, 2'd2, 32'h0};
    resetVecs[6] = '{3'd4, 2'd1, 32'h0};
    resetVecs[7] = '{3'd5, 2'd0, 32'h0060_0000};
    resetVecs[8] = '{3'd6, 2'd0, 32'h0};
    resetVecs[9] = '{3'd7, 2'd0, 32'h0};

    wrVecs[0]  = '{3'd5, {128{1'b1}}, 3'd5, 2'd0, 32'hFFFF_FFFF};
    wrVecs[1]  = '{3'd5, {128{1'b1}}, 3'd5, 2'd1, 32'h0};
    wrVecs[2]  = '{3'd1, 128'hABCD_1234, 3'd1, 2'd0, 32'h0000_1234};
    wrVecs[3]  = '{3'd7, {128{1'b1}}, 3'd1, 2'd0, 32'h0000_1234};
    wrVecs[4]  = '{3'd7, {128{1'b1}}, 3'd2, 2'd0, 32'h0000_0404};
    wrVecs[5]  = '{3'd6, 128'h0123_4567_89AB_CDEF, 3'd6, 2'd1, 32'h0123_4567};
    wrVecs[6]  = '{3'd6, 128'h0123_4567_89AB_CDEF, 3'd6, 2'd0, 32'h89AB_CDEF};
    wrVecs[7]  = '{3'd2, 128'h1_BEEF, 3'd2, 2'd0, 32'h0000_BEEF};
    wrVecs[8]  = '{3'd3, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 3'd3, 2'd2, 32'h7654_3210};
    wrVecs[9]  = '{3'd4, 128'hFFFF_0000_1111_2222_3333_4444_5555_6666, 3'd4, 2'd2, 32'h0};
    wrVecs[10] = '{3'd7, {128{1'b1}}, 3'd7, 2'd0, 32'h0};

    reset = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    ld_start = 1'b0; ld_sel = '0; ld_bit_valid = 1'b0; ld_bit = 1'b0; ld_abort = 1'b0;
    rd_sel = '0; rd_word = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset values");
    runResetTable();

    // Mid-load, mid-cycle reset restores everything at once.
    $display("[TB] reset during a load");
    parWrite(3'd2, 128'hFFFF);
    parWrite(3'd5, 128'h1111_2222);
    startLoad(3'd6);
    sendStream(136'h3FF, 10, 0, 1'b0, 3'd0, 128'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_busy", {127'd0, ld_busy}, 128'd0);
    checkOutput("rst_done", {127'd0, ld_done}, 128'd0);
    checkOutput("rst_err",  {127'd0, ld_err},  128'd0);
    runResetTable();
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] parallel writes");
    for (int i = 0; i < 11; i++) begin
      parWrite(wrVecs[i].wsel, wrVecs[i].wdata);
      readCheck($sformatf("wr_vec%0d", i), wrVecs[i].rsel, wrVecs[i].rword, wrVecs[i].exp);
    end
    checkOutput("wr_rca_out", {112'd0, rca_out}, {112'd0, 16'h1234});

    // RCA load with valid gaps; DSR written on the final bit goes to a different target.
    $display("[TB] serial RCA load");
    expQ.push_back(1'b0);
    startLoad(3'd1);
    checkOutput("rca_busy_start", {127'd0, ld_busy}, {127'd0, 1'b1});
    s = mkStream(128'hB3A5, 16, 1'b0);
    sendStream(s, 16 + CRC_LEN, 3, 1'b1, 3'd2, 128'h5A5A);
    checkOutput("rca_done", {127'd0, ld_done}, {127'd0, 1'b1});
    checkOutput("rca_busy_end", {127'd0, ld_busy}, 128'd0);
    checkOutput("rca_out", {112'd0, rca_out}, {112'd0, 16'hB3A5});
    readCheck("dsr_side_write", 3'd2, 2'd0, 32'h0000_5A5A);

    // Back-to-back: new start accepted in the done cycle.
    expQ.push_back(1'b0);
    ld_start = 1'b1;
    ld_sel   = 3'd4;
    @(negedge clk);
    ld_start = 1'b0;
    checkOutput("scr_busy_b2b", {127'd0, ld_busy}, {127'd0, 1'b1});
    s = mkStream(128'h8001_2345_6789_FEDC, 64, 1'b0);
    sendStream(s, 64 + CRC_LEN, 0, 1'b0, 3'd0, 128'd0);
    readCheck("scr_w1", 3'd4, 2'd1, 32'h8001_2345);
    readCheck("scr_w0", 3'd4, 2'd0, 32'h6789_FEDC);

    $display("[TB] serial CID load");
    expQ.push_back(1'b0);
    startLoad(3'd0);
    s = mkStream(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128, 1'b0);
    sendStream(s, 128 + CRC_LEN, 5, 1'b0, 3'd0, 128'd0);
    readCheck("cid_w3", 3'd0, 2'd3, 32'h0123_4567);
    readCheck("cid_w2", 3'd0, 2'd2, 32'h89AB_CDEF);
    readCheck("cid_w1", 3'd0, 2'd1, 32'hFEDC_BA98);
    readCheck("cid_w0", 3'd0, 2'd0, 32'h7654_3210);

    $display("[TB] STAT abort after 40 bits");
    startLoad(3'd6);
    sendStream({136{1'b1}}, 40, 0, 1'b0, 3'd0, 128'd0);
    expQ.push_back(1'b1);
    ld_abort = 1'b1;
    @(negedge clk);
    ld_abort = 1'b0;
    checkOutput("abort_done", {127'd0, ld_done}, {127'd0, 1'b1});
    checkOutput("abort_busy", {127'd0, ld_busy}, 128'd0);
    readCheck("abort_stat_w1", 3'd6, 2'd1, 32'h0123_4567);
    readCheck("abort_stat_w0", 3'd6, 2'd0, 32'h89AB_CDEF);

    $display("[TB] OCR commit collides with parallel write");
    expQ.push_back(1'b1);
    startLoad(3'd5);
    s = mkStream(128'hA5A5_0F0F, 32, 1'b0);
    sendStream(s, 32 + CRC_LEN, 0, 1'b1, 3'd5, 128'h1234_5678);
    checkOutput("collide_done", {127'd0, ld_done}, {127'd0, 1'b1});
    readCheck("collide_ocr", 3'd5, 2'd0, 32'h1234_5678);

    $display("[TB] reserved load target");
    expQ.push_back(1'b1);
    startLoad(3'd7);
    checkOutput("sel7_busy", {127'd0, ld_busy}, 128'd0);
    checkOutput("sel7_done", {127'd0, ld_done}, {127'd0, 1'b1});

`ifdef SD_REG_CRC7_EN
    $display("[TB] CSD load with CRC");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expQ.push_back(1'b1);
    startLoad(3'd3);
    s = mkStream(128'h400E_0032_5B59_0000_1D8A_7F80_0A40_0040, 128, 1'b1);
    sendStream(s, 135, 0, 1'b0, 3'd0, 128'd0);
    readCheck("crc_bad_csd_w3", 3'd3, 2'd3, 32'h0000_0048);
    readCheck("crc_bad_csd_w0", 3'd3, 2'd0, 32'h0);
    expQ.push_back(1'b0);
    startLoad(3'd3);
    s = mkStream(128'h400E_0032_5B59_0000_1D8A_7F80_0A40_0040, 128, 1'b0);
    sendStream(s, 135, 0, 1'b0, 3'd0, 128'd0);
    readCheck("crc_ok_csd_w3", 3'd3, 2'd3, 32'h400E_0032);
    readCheck("crc_ok_csd_w0", 3'd3, 2'd0, 32'h0A40_0040);
`endif

    repeat (3) @(negedge clk);
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL missing_done: got %0d pending, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
